// File: rtl/usb_rx_line_decoder.sv
// Receive-side USB line decoder: samples DP/DM once per bit, hunts for SYNC,
// forwards raw J/K levels, validates EOP and reports line/overflow/timeout errors.
module usb_rx_line_decoder #(
  parameter int SYNC_PAIRS   = 3,
  parameter int MAX_BITS     = 88,
  parameter int EOP_SE0      = 2,
  parameter int HUNT_TIMEOUT = 32,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_bus_in,
  input  logic             i_tx_active,
  input  logic             i_arm,
  input  logic             i_err_ack,
  output logic             o_busy,
  output logic             o_sop,
  output logic             o_bit_valid,
  output logic             o_bit_out,
  output logic             o_eop,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic [CNT_W-1:0] o_bit_count
);

  typedef enum logic [2:0] {S_IDLE, S_HUNT, S_SYNC, S_DATA, S_EOP, S_ERROR} state_e;
  typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_LINE = 2'b01,
                            ERR_OVF  = 2'b10, ERR_TMO  = 2'b11} err_code_e;

  localparam logic [1:0] SYM_J = 2'b10;
  localparam logic [1:0] SYM_K = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  // SYNC is 2*SYNC_PAIRS alternating K/J symbols followed by two Ks.
  localparam int IDX_W = $clog2(2 * SYNC_PAIRS + 2);
  localparam logic [IDX_W-1:0] IDX_PAIRS = IDX_W'(2 * SYNC_PAIRS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(2 * SYNC_PAIRS + 1);
  localparam int SE0_W = $clog2(EOP_SE0 + 2);
  localparam logic [SE0_W-1:0] SE0_MAX = SE0_W'(EOP_SE0);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(HUNT_TIMEOUT - 1);

  state_e           r_state;
  err_code_e        r_err_code;
  logic [IDX_W-1:0] r_idx;
  logic [SE0_W-1:0] r_se0;
  logic [CNT_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_bit_count;
  logic             r_busy, r_sop, r_bit_valid, r_bit_out, r_eop, r_err;

  logic w_is_j, w_is_k, w_is_se0, w_expect_j, w_sync_match;

  assign w_is_j       = (i_bus_in == SYM_J);
  assign w_is_k       = (i_bus_in == SYM_K);
  assign w_is_se0     = (i_bus_in == SYM_SE0);
  assign w_expect_j   = (r_idx < IDX_PAIRS) && r_idx[0];
  assign w_sync_match = w_expect_j ? w_is_j : w_is_k;

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every register updates from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_err_code  <= ERR_NONE;
      r_idx       <= '0;
      r_se0       <= '0;
      r_tmo       <= '0;
      r_bit_count <= '0;
      r_busy      <= 1'b0;
      r_sop       <= 1'b0;
      r_bit_valid <= 1'b0;
      r_bit_out   <= 1'b0;
      r_eop       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sop       <= 1'b0;
      r_bit_valid <= 1'b0;
      r_eop       <= 1'b0;
      // While our own transmitter drives the bus everything freezes.
      if (!i_tx_active) begin
        case (r_state)
          S_IDLE: if (i_arm) begin
            r_state <= S_HUNT;
            r_tmo   <= '0;
            r_busy  <= 1'b1;
          end
          S_HUNT: begin
            if (w_is_k) begin
              r_state <= S_SYNC;
              r_idx   <= IDX_W'(1);
            end else if (r_tmo == TMO_LAST) begin
              r_state    <= S_ERROR;
              r_err      <= 1'b1;
              r_err_code <= ERR_TMO;
            end else begin
              r_tmo <= r_tmo + CNT_W'(1);
            end
          end
          S_SYNC: begin
            if (!w_sync_match) begin
              r_state <= S_HUNT;
            end else if (r_idx == IDX_LAST) begin
              r_state     <= S_DATA;
              r_sop       <= 1'b1;
              r_bit_count <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
          S_DATA: begin
            if (w_is_j || w_is_k) begin
              if (r_bit_count == MAX_CNT) begin
                r_state    <= S_ERROR;
                r_err      <= 1'b1;
                r_err_code <= ERR_OVF;
              end else begin
                r_bit_valid <= 1'b1;
                r_bit_out   <= w_is_j;
                r_bit_count <= r_bit_count + CNT_W'(1);
              end
            end else if (w_is_se0) begin
              r_state <= S_EOP;
              r_se0   <= SE0_W'(1);
            end else begin
              r_state    <= S_ERROR;
              r_err      <= 1'b1;
              r_err_code <= ERR_LINE;
            end
          end
          S_EOP: begin
            if (w_is_se0 && (r_se0 != SE0_MAX)) begin
              r_se0 <= r_se0 + SE0_W'(1);
            end else if (w_is_j && (r_se0 == SE0_MAX)) begin
              r_state <= S_IDLE;
              r_eop   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= S_ERROR;
              r_err      <= 1'b1;
              r_err_code <= ERR_LINE;
            end
          end
          S_ERROR: if (i_err_ack) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_busy     <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_sop       = r_sop;
  assign o_bit_valid = r_bit_valid;
  assign o_bit_out   = r_bit_out;
  assign o_eop       = r_eop;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;
  assign o_bit_count = r_bit_count;

endmodule
